// File: rtl/cp0_exception_regs.sv
// -----------------------------------------------------------------------------
// cp0_exception_regs
//
// CP0 register file that sits at the receiving end of the exception unit.
// It records exception reports (EPC, ExcCode, BD, BadVAddr, EXL), services
// MTC0 writes and combinational MFC0 reads, and runs the Count/Compare timer.
// Interrupt, vector-base and EPC state are fed back to the exception unit
// every cycle.
//
// Optional feature: define CP0_TIMER_EN to build the Count/Compare timer.
// Without it Count/Compare read as 0, ignore writes, and TI is tied to 0.
//
// Ports
//   clk, resetn         clock, asynchronous active-low reset
//   mtc0_we, cp0_waddr, cp0_wsel, cp0_wdata   MTC0 write port
//   cp0_raddr, cp0_rsel, cp0_rdata            MFC0 read port (combinational)
//   cp0_wr_exp          exception taken this cycle
//   cp0_clean_exl       ERET retiring
//   exp_epc, exp_code, exp_in_delayslot, exp_bad_vaddr, cp0_badv_we
//                       exception report fields
//   hw_int              level-sensitive hardware interrupt lines
//   interrupt_flags     Cause.IP & Status.IM
//   allow_int           Status.{ERL,EXL,IE} == 3'b001
//   ebase_out           EBase[31:12]
//   epc_out             EPC
//   special_int_vec     Cause.IV
//   boot_exp_vec        Status.BEV
//   timer_int           Cause.TI
// -----------------------------------------------------------------------------
module cp0_exception_regs #(
  parameter logic [31:0] EBASE_RESET = 32'h80000000,
  parameter int          COUNT_DIV   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [2:0]  cp0_wsel,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  input  logic [2:0]  cp0_rsel,
  output logic [31:0] cp0_rdata,
  input  logic        cp0_wr_exp,
  input  logic        cp0_clean_exl,
  input  logic [31:0] exp_epc,
  input  logic [4:0]  exp_code,
  input  logic        exp_in_delayslot,
  input  logic [31:0] exp_bad_vaddr,
  input  logic        cp0_badv_we,
  input  logic [5:0]  hw_int,
  output logic [7:0]  interrupt_flags,
  output logic        allow_int,
  output logic [19:0] ebase_out,
  output logic [31:0] epc_out,
  output logic        special_int_vec,
  output logic        boot_exp_vec,
  output logic        timer_int
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_EBASE    = 5'd15;

  // Status fields
  logic        status_bev;
  logic [7:0]  status_im;
  logic        status_erl;
  logic        status_exl;
  logic        status_ie;

  // Cause fields
  logic        cause_bd;
  logic        cause_ti;
  logic        cause_iv;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc_code;

  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [17:0] ebase_rw;     // EBase[29:12]; the remaining bits are fixed

  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  logic wr_status, wr_cause, wr_epc, wr_ebase;

  assign wr_status = mtc0_we && (cp0_waddr == REG_STATUS) && (cp0_wsel == 3'd0);
  assign wr_cause  = mtc0_we && (cp0_waddr == REG_CAUSE)  && (cp0_wsel == 3'd0);
  assign wr_epc    = mtc0_we && (cp0_waddr == REG_EPC)    && (cp0_wsel == 3'd0);
  assign wr_ebase  = mtc0_we && (cp0_waddr == REG_EBASE)  && (cp0_wsel == 3'd1);

  // NOTE: every register here is reset asynchronously and updated with
  // non-blocking assignments so all blocks see the pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_bev <= 1'b1;
      status_im  <= '0;
      status_erl <= 1'b0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        status_bev <= cp0_wdata[22];
        status_im  <= cp0_wdata[15:8];
        status_erl <= cp0_wdata[2];
        status_ie  <= cp0_wdata[0];
      end
      // Exception beats ERET, and both beat a software write of EXL.
      if (cp0_wr_exp)         status_exl <= 1'b1;
      else if (cp0_clean_exl) status_exl <= 1'b0;
      else if (wr_status)     status_exl <= cp0_wdata[1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_bd       <= 1'b0;
      cause_iv       <= 1'b0;
      cause_ip       <= '0;
      cause_exc_code <= '0;
    end else begin
      if (wr_cause) begin
        cause_iv      <= cp0_wdata[23];
        cause_ip[1:0] <= cp0_wdata[9:8];
      end
      // Hardware lines are resampled every cycle; the timer shares IP7.
      cause_ip[7:2] <= {hw_int[5] | cause_ti, hw_int[4:0]};
      if (cp0_wr_exp) begin
        cause_exc_code <= exp_code;
        // A nested exception keeps the original BD/EPC pair.
        if (!status_exl) cause_bd <= exp_in_delayslot;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc      <= '0;
      badvaddr <= '0;
      ebase_rw <= EBASE_RESET[29:12];
    end else begin
      if (cp0_wr_exp) begin
        if (!status_exl) epc <= exp_epc;
      end else if (wr_epc) begin
        epc <= cp0_wdata;
      end
      if (cp0_wr_exp && cp0_badv_we) badvaddr <= exp_bad_vaddr;
      if (wr_ebase) ebase_rw <= cp0_wdata[29:12];
    end
  end

`ifdef CP0_TIMER_EN
  localparam int                 DIV_W   = (COUNT_DIV > 0) ? COUNT_DIV : 1;
  localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'((1 << COUNT_DIV) - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [31:0]      count;
  logic [31:0]      compare;
  logic             div_wrap;
  logic             wr_count, wr_compare;

  assign wr_count   = mtc0_we && (cp0_waddr == REG_COUNT)   && (cp0_wsel == 3'd0);
  assign wr_compare = mtc0_we && (cp0_waddr == REG_COMPARE) && (cp0_wsel == 3'd0);
  assign div_wrap   = (div_cnt == DIV_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt  <= '0;
      count    <= '0;
      compare  <= '0;
      cause_ti <= 1'b0;
    end else begin
      // A software Count write restarts the prescaler so the new value
      // is held for a full 2^COUNT_DIV cycles.
      if (wr_count) begin
        count   <= cp0_wdata;
        div_cnt <= '0;
      end else begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
        if (div_wrap) count <= count + 32'd1;
      end
      if (wr_compare) compare <= cp0_wdata;
      // Writing Compare acknowledges the timer even if a match is seen now.
      if (wr_compare)            cause_ti <= 1'b0;
      else if (count == compare) cause_ti <= 1'b1;
    end
  end

  assign count_rd   = count;
  assign compare_rd = compare;
`else
  localparam int unused_count_div = COUNT_DIV;
  assign cause_ti   = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  // NOTE: the default assignment first keeps this combinational mux latch-free.
  always_comb begin
    cp0_rdata = '0;
    case ({cp0_raddr, cp0_rsel})
      {REG_BADVADDR, 3'd0}: cp0_rdata = badvaddr;
      {REG_COUNT,    3'd0}: cp0_rdata = count_rd;
      {REG_COMPARE,  3'd0}: cp0_rdata = compare_rd;
      {REG_STATUS,   3'd0}: cp0_rdata = {9'b0, status_bev, 6'b0, status_im, 5'b0,
                                         status_erl, status_exl, status_ie};
      {REG_CAUSE,    3'd0}: cp0_rdata = {cause_bd, cause_ti, 6'b0, cause_iv, 7'b0,
                                         cause_ip, 1'b0, cause_exc_code, 2'b0};
      {REG_EPC,      3'd0}: cp0_rdata = epc;
      {REG_EBASE,    3'd1}: cp0_rdata = {EBASE_RESET[31:30], ebase_rw, EBASE_RESET[11:0]};
      default:              cp0_rdata = '0;
    endcase
  end

  assign interrupt_flags = cause_ip & status_im;
  assign allow_int       = ({status_erl, status_exl, status_ie} == 3'b001);
  assign ebase_out       = {EBASE_RESET[31:30], ebase_rw};
  assign epc_out         = epc;
  assign special_int_vec = cause_iv;
  assign boot_exp_vec    = status_bev;
  assign timer_int       = cause_ti;

endmodule

// File: doc/cp0_exception_regs.md
Name: cp0_exception_regs

Overview:
- CP0 register file; the receiving end of the exception unit's reporting interface.
- Captures exception reports (EPC, ExcCode, BadVAddr, EXL set/clear) and services MTC0/MFC0 accesses.
- Runs the Count/Compare timer.
- Feeds interrupt, vector-base and EPC state back to the exception unit every cycle.

Parameters:
- EBASE_RESET, 32'h80000000, reset value of EBase; only bits [29:12] are writable.
- COUNT_DIV, 1, Count increments once per 2^COUNT_DIV cycles (1 = every other cycle).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mtc0_we  in  1  MTC0 write strobe
- cp0_waddr  in  5  MTC0 register number
- cp0_wsel  in  3  MTC0 select
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  5  MFC0 register number
- cp0_rsel  in  3  MFC0 select
- cp0_rdata  out  32  MFC0 data (combinational)
- cp0_wr_exp  in  1  exception taken this cycle
- cp0_clean_exl  in  1  ERET retiring
- exp_epc  in  32  EPC to record
- exp_code  in  5  ExcCode to record
- exp_in_delayslot  in  1  faulting instruction sits in a delay slot
- exp_bad_vaddr  in  32  faulting address
- cp0_badv_we  in  1  BadVAddr write enable
- hw_int  in  6  hardware interrupt lines (level)
- interrupt_flags  out  8  Cause.IP & Status.IM
- allow_int  out  1  Status[2:0]==3'b001
- ebase_out  out  20  EBase[31:12]
- epc_out  out  32  EPC
- special_int_vec  out  1  Cause.IV
- boot_exp_vec  out  1  Status.BEV
- timer_int  out  1  Cause.TI

Behaviour:
- Register map (reg/sel):
  - BadVAddr 8/0: read-only to MTC0.
  - Count 9/0.
  - Compare 11/0.
  - Status 12/0: writable bits BEV[22], IM[15:8], ERL[2], EXL[1], IE[0].
  - Cause 13/0: BD[31], TI[30], IV[23], IP[15:8], ExcCode[6:2]; writable bits IV and IP[1:0] only.
  - EPC 14/0: fully writable.
  - EBase 15/1.
  - Unmapped reads return 0; unmapped writes are ignored.
- Reset: all registers 0, except Status=32'h00400000 (BEV=1) and EBase=EBASE_RESET.
  - Outputs at reset: boot_exp_vec=1, allow_int=0, interrupt_flags=0, epc_out=0, ebase_out=EBASE_RESET[31:12], timer_int=0.
- IP[7:2] is resampled every cycle as {hw_int[5]|TI, hw_int[4:0]}: one-cycle latency from hw_int to interrupt_flags.
- Exception (cp0_wr_exp=1), applied at the clock edge:
  - ExcCode<=exp_code.
  - If EXL==0: EPC<=exp_epc, BD<=exp_in_delayslot.
  - If EXL==1: EPC and BD are held.
  - EXL<=1.
  - If cp0_badv_we: BadVAddr<=exp_bad_vaddr.
- ERET (cp0_clean_exl=1, cp0_wr_exp=0): EXL<=0; all other fields unchanged.
- cp0_wr_exp and cp0_clean_exl both high: treated as an exception; EXL ends at 1.
- Same-cycle MTC0 and exception:
  - Exception wins for EPC, Cause.BD/ExcCode, Status.EXL and BadVAddr.
  - The MTC0 still updates the non-conflicting fields and registers, e.g. Count, Compare, IM.
- Timer:
  - A divider toggles every cycle; Count+1 is applied when the divider wraps.
  - Count wraps from 32'hFFFFFFFF to 0 with no flag.
  - MTC0 to Count overrides the increment that cycle and resets the divider.
  - TI is set on the edge after Count==Compare is observed, and stays set until an MTC0 to Compare.
  - A Compare write and a match in the same cycle: the clear wins, so TI=0.
- MFC0 reads return the current register contents: a same-cycle write is visible only on the following cycle.
- resetn asserted mid-operation: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: Count/Compare/TI behave as described above.
- Undefined:
  - Count and Compare read 0; writes to them are ignored.
  - TI and timer_int are constant 0.
  - IP7 = hw_int[5] only.
  - No divider or comparator logic is present.

Test Plan:
- Release resetn -> cp0_rdata for 12/0 = 32'h00400000; ebase_out=20'h80000, boot_exp_vec=1, allow_int=0.
- MTC0 Status=32'h0000FF01, assert hw_int=6'b000001 -> next cycle interrupt_flags=8'h04, allow_int=1; exception with exp_code=0, exp_epc=32'hBFC00380 -> EPC=32'hBFC00380, EXL=1, allow_int=0.
- Exception with exp_epc=32'h100 while EXL=1 -> EPC stays at its prior value; ExcCode updates; then ERET -> EXL=0, epc_out unchanged.
- Exception with cp0_badv_we=1, exp_bad_vaddr=32'h00000003, exp_code=5'h04, exp_in_delayslot=1 -> BadVAddr=3, Cause[31]=1, Cause[6:2]=4.
- MTC0 Count=32'hFFFFFFFE, Compare=0 -> Count wraps to 0 after 4 cycles; timer_int=1 one cycle after the match; MTC0 Compare -> timer_int=0.
- Same-cycle MTC0 EPC=32'h1234 and exception with exp_epc=32'h5678 (EXL=0) -> EPC=32'h5678.
